// File: rtl/dfi_init_seq.sv
// dfi_init_seq: bridges the memory controller's DFI init handshake to the
// dfi_gpio firmware pair. It qualifies the start request, forwards it, waits
// for a fresh rising edge on the firmware done level, and raises a sticky
// timeout flag if firmware never answers.
module dfi_init_seq #(
  parameter int FREQ_W           = 5,
  parameter int MIN_START_CYCLES = 4,
  parameter int TIMEOUT_CYCLES   = 100000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              dfi_init_start_i,
  input  logic [FREQ_W-1:0] dfi_frequency_i,
  output logic              dfi_init_complete_o,
  output logic              gpio_init_start_o,
  input  logic              gpio_init_done_i,
  output logic [FREQ_W-1:0] freq_o,
  output logic              busy_o,
  output logic              timeout_o,
  input  logic              timeout_clr_i
);

  localparam int CNT_MAX = (MIN_START_CYCLES > TIMEOUT_CYCLES) ? MIN_START_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // Terminal counts for the qualification window and the done wait.
  // A timeout of zero never matches because the compare is also gated.
  localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MIN_START_CYCLES);
  localparam logic [CNT_W-1:0] TO_LAST  = (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic             TO_EN    = (TIMEOUT_CYCLES != 0);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_DONE = 3'd2,
    ACK       = 3'd3,
    ERROR     = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  cnt_inc;
  logic              done_q;
  logic              done_rise;
  logic              complete_q, complete_d;
  logic              gpio_start_q, gpio_start_d;
  logic [FREQ_W-1:0] freq_q, freq_d;
  logic              busy_q, busy_d;
  logic              timeout_q, timeout_d;

  // Only a fresh 0->1 on the firmware level counts; a level left high from a
  // previous handshake is stale.
  assign done_rise = gpio_init_done_i & ~done_q;

  // The counter sticks at all-ones instead of wrapping.
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  // Next-state, counter and registered-output logic for the handshake FSM.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    complete_d   = complete_q;
    gpio_start_d = gpio_start_q;
    freq_d       = freq_q;
    timeout_d    = timeout_q;

    case (state_q)
      IDLE: begin
        gpio_start_d = 1'b0;
        if (dfi_init_start_i) begin
          state_d    = START;
          freq_d     = dfi_frequency_i;
          cnt_d      = CNT_W'(1);
          complete_d = 1'b0;
        end
      end

      START: begin
        gpio_start_d = 1'b0;
        if (!dfi_init_start_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == MIN_LAST) begin
          state_d      = WAIT_DONE;
          gpio_start_d = 1'b1;
          cnt_d        = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      WAIT_DONE: begin
        gpio_start_d = 1'b1;
        if (!dfi_init_start_i) begin
          state_d      = IDLE;
          gpio_start_d = 1'b0;
          cnt_d        = '0;
        end else if (done_rise) begin
          state_d    = ACK;
          complete_d = 1'b1;
          cnt_d      = '0;
        end else if (TO_EN && (cnt_q == TO_LAST)) begin
          state_d      = ERROR;
          gpio_start_d = 1'b0;
          cnt_d        = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      ACK: begin
        complete_d   = 1'b1;
        gpio_start_d = 1'b1;
        if (!dfi_init_start_i) begin
          state_d      = IDLE;
          gpio_start_d = 1'b0;
        end
      end

      ERROR: begin
        complete_d   = 1'b0;
        gpio_start_d = 1'b0;
        if (!dfi_init_start_i) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d      = IDLE;
        cnt_d        = '0;
        gpio_start_d = 1'b0;
      end
    endcase

    // Clear first so that entering ERROR in the same cycle wins.
    if (timeout_clr_i) begin
      timeout_d = 1'b0;
    end
    if ((state_q == WAIT_DONE) && (state_d == ERROR)) begin
      timeout_d = 1'b1;
    end

    busy_d = (state_d == START) || (state_d == WAIT_DONE) || (state_d == ACK);
  end

  // State, counter, done history and all outputs, with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      done_q       <= 1'b0;
      complete_q   <= 1'b0;
      gpio_start_q <= 1'b0;
      freq_q       <= '0;
      busy_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      done_q       <= gpio_init_done_i;
      complete_q   <= complete_d;
      gpio_start_q <= gpio_start_d;
      freq_q       <= freq_d;
      busy_q       <= busy_d;
      timeout_q    <= timeout_d;
    end
  end

  assign dfi_init_complete_o = complete_q;
  assign gpio_init_start_o   = gpio_start_q;
  assign freq_o              = freq_q;
  assign busy_o              = busy_q;
  assign timeout_o           = timeout_q;

endmodule

// File: tb/tb_dfi_init_seq.sv
// Directed bench for dfi_init_seq with MIN_START_CYCLES=4, TIMEOUT_CYCLES=16.
// Expected outputs are hand-derived and checked one cycle at a time.
module tb_dfi_init_seq;

  localparam int FREQ_W = 5;

  logic              clk;
  logic              rst;
  logic              startIn;
  logic [FREQ_W-1:0] freqIn;
  logic              doneIn;
  logic              clrIn;
  logic              completeOut;
  logic              gpioStartOut;
  logic [FREQ_W-1:0] freqOut;
  logic              busyOut;
  logic              timeoutOut;

  int vectorCount = 0;
  int missCount   = 0;

  dfi_init_seq #(
    .FREQ_W          (FREQ_W),
    .MIN_START_CYCLES(4),
    .TIMEOUT_CYCLES  (16)
  ) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .dfi_init_start_i   (startIn),
    .dfi_frequency_i    (freqIn),
    .dfi_init_complete_o(completeOut),
    .gpio_init_start_o  (gpioStartOut),
    .gpio_init_done_i   (doneIn),
    .freq_o             (freqOut),
    .busy_o             (busyOut),
    .timeout_o          (timeoutOut),
    .timeout_clr_i      (clrIn)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive the functional inputs; they are sampled at the next rising edge.
  task automatic applyStimulus(input logic start, input logic [FREQ_W-1:0] freq,
                               input logic done, input logic clr);
    startIn = start;
    freqIn  = freq;
    doneIn  = done;
    clrIn   = clr;
  endtask

  // Compare every output against one expected tuple {complete,gpio,freq,busy,timeout}.
  task automatic checkOutput(input string tag, input logic comp, input logic gpio,
                             input logic [FREQ_W-1:0] freq, input logic busy, input logic to);
    logic [FREQ_W+3:0] obs;
    logic [FREQ_W+3:0] exp;
    obs = {completeOut, gpioStartOut, freqOut, busyOut, timeoutOut};
    exp = {comp, gpio, freq, busy, to};
    vectorCount++;
    assert (obs === exp) else begin
      missCount++;
      $error("[TB] FAIL %s: observed cmp=%b gpio=%b freq=%0d busy=%b to=%b, expected cmp=%b gpio=%b freq=%0d busy=%b to=%b",
             tag, completeOut, gpioStartOut, freqOut, busyOut, timeoutOut,
             comp, gpio, freq, busy, to);
    end
  endtask

  // Advance n edges with inputs held, checking the same expectation after each.
  task automatic runCheck(input string tag, input int n, input logic comp, input logic gpio,
                          input logic [FREQ_W-1:0] freq, input logic busy, input logic to);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      checkOutput(tag, comp, gpio, freq, busy, to);
    end
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0);
    runCheck("reset", 2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    rst = 1'b0;
    runCheck("idle", 1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);

    $display("[TB] nominal handshake");
    applyStimulus(1'b1, 5'd3, 1'b0, 1'b0);
    runCheck("nom_accept", 1, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0);
    applyStimulus(1'b1, 5'd9, 1'b0, 1'b0);
    runCheck("nom_qualify", 3, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0);
    runCheck("nom_gpio_rise", 1, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0);
    runCheck("nom_wait", 5, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0);
    applyStimulus(1'b1, 5'd9, 1'b1, 1'b0);
    runCheck("nom_ack", 5, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
    applyStimulus(1'b0, 5'd9, 1'b0, 1'b0);
    runCheck("nom_release", 2, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0);

    $display("[TB] start glitch");
    applyStimulus(1'b1, 5'd10, 1'b0, 1'b0);
    runCheck("glitch_start", 2, 1'b0, 1'b0, 5'd10, 1'b1, 1'b0);
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0);
    runCheck("glitch_reject", 6, 1'b0, 1'b0, 5'd10, 1'b0, 1'b0);

    $display("[TB] stale done level");
    applyStimulus(1'b0, 5'd0, 1'b1, 1'b0);
    runCheck("stale_pre", 2, 1'b0, 1'b0, 5'd10, 1'b0, 1'b0);
    applyStimulus(1'b1, 5'd4, 1'b1, 1'b0);
    runCheck("stale_start", 4, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0);
    runCheck("stale_wait", 6, 1'b0, 1'b1, 5'd4, 1'b1, 1'b0);
    applyStimulus(1'b1, 5'd4, 1'b0, 1'b0);
    runCheck("stale_drop", 1, 1'b0, 1'b1, 5'd4, 1'b1, 1'b0);
    applyStimulus(1'b1, 5'd4, 1'b1, 1'b0);
    runCheck("stale_rise_ack", 1, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0);
    runCheck("stale_release", 1, 1'b1, 1'b0, 5'd4, 1'b0, 1'b0);

    $display("[TB] timeout");
    applyStimulus(1'b1, 5'd17, 1'b0, 1'b0);
    runCheck("to_start", 4, 1'b0, 1'b0, 5'd17, 1'b1, 1'b0);
    runCheck("to_wait", 16, 1'b0, 1'b1, 5'd17, 1'b1, 1'b0);
    runCheck("to_fire", 1, 1'b0, 1'b0, 5'd17, 1'b0, 1'b1);
    runCheck("to_hold_err", 3, 1'b0, 1'b0, 5'd17, 1'b0, 1'b1);
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0);
    runCheck("to_exit_err", 1, 1'b0, 1'b0, 5'd17, 1'b0, 1'b1);
    applyStimulus(1'b1, 5'd2, 1'b0, 1'b0);
    runCheck("to_restart", 1, 1'b0, 1'b0, 5'd2, 1'b1, 1'b1);
    applyStimulus(1'b1, 5'd2, 1'b0, 1'b1);
    runCheck("to_clear", 1, 1'b0, 1'b0, 5'd2, 1'b1, 1'b0);
    applyStimulus(1'b1, 5'd2, 1'b0, 1'b0);
    runCheck("to2_start", 2, 1'b0, 1'b0, 5'd2, 1'b1, 1'b0);
    runCheck("to2_wait", 16, 1'b0, 1'b1, 5'd2, 1'b1, 1'b0);
    applyStimulus(1'b1, 5'd2, 1'b0, 1'b1);
    runCheck("to_set_beats_clr", 1, 1'b0, 1'b0, 5'd2, 1'b0, 1'b1);
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0);
    runCheck("to2_exit_err", 1, 1'b0, 1'b0, 5'd2, 1'b0, 1'b1);
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b1);
    runCheck("to_clear_idle", 1, 1'b0, 1'b0, 5'd2, 1'b0, 1'b0);

    $display("[TB] abort in wait");
    applyStimulus(1'b1, 5'd8, 1'b0, 1'b0);
    runCheck("abort_start", 4, 1'b0, 1'b0, 5'd8, 1'b1, 1'b0);
    runCheck("abort_wait", 3, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0);
    applyStimulus(1'b0, 5'd0, 1'b1, 1'b0);
    runCheck("abort_idle", 2, 1'b0, 1'b0, 5'd8, 1'b0, 1'b0);

    $display("[TB] reset in wait");
    applyStimulus(1'b1, 5'd21, 1'b0, 1'b0);
    runCheck("rst_start", 4, 1'b0, 1'b0, 5'd21, 1'b1, 1'b0);
    runCheck("rst_wait", 3, 1'b0, 1'b1, 5'd21, 1'b1, 1'b0);
    rst = 1'b1;
    runCheck("rst_mid", 1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    rst = 1'b0;
    applyStimulus(1'b1, 5'd12, 1'b0, 1'b0);
    runCheck("post_rst_start", 4, 1'b0, 1'b0, 5'd12, 1'b1, 1'b0);
    runCheck("post_rst_wait", 2, 1'b0, 1'b1, 5'd12, 1'b1, 1'b0);
    applyStimulus(1'b1, 5'd12, 1'b1, 1'b0);
    runCheck("post_rst_ack", 2, 1'b1, 1'b1, 5'd12, 1'b1, 1'b0);
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0);
    runCheck("post_rst_release", 1, 1'b1, 1'b0, 5'd12, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule

// File: doc/dfi_init_seq.md
Name: dfi_init_seq

Overview:
- Upstream stage of the dfi_gpio peripheral. Bridges the memory controller's DFI initialization handshake (dfi_init_start / dfi_init_complete) to the firmware-visible GPIO pair.
- Drives dfi_gpio's init-start input and consumes its init-done output.
- Adds start qualification, rising-edge detection on done, frequency capture, and a bounded wait with a sticky timeout flag.

Parameters:
- FREQ_W, 5, width of dfi_frequency.
- MIN_START_CYCLES, 4, consecutive cycles dfi_init_start_i must stay high before the request is forwarded; must be >= 1.
- TIMEOUT_CYCLES, 100000, maximum WAIT_DONE cycles; 0 disables the timeout.
- CNT_W, $clog2(max(MIN_START_CYCLES,TIMEOUT_CYCLES)+1), internal counter width (derived).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- dfi_init_start_i  in  1  init request from the memory controller (level).
- dfi_frequency_i  in  FREQ_W  target frequency index; valid while dfi_init_start_i is high.
- dfi_init_complete_o  out  1  init-complete to the memory controller.
- gpio_init_start_o  out  1  to dfi_gpio dfi_init_start_i.
- gpio_init_done_i  in  1  from dfi_gpio dfi_init_done_o (firmware-written level).
- freq_o  out  FREQ_W  frequency captured at request acceptance.
- busy_o  out  1  high in START, WAIT_DONE, ACK.
- timeout_o  out  1  sticky timeout flag.
- timeout_clr_i  in  1  single-cycle clear for timeout_o.

Behaviour:
- All outputs are registered. An input sampled at edge N affects outputs after edge N (visible in cycle N+1).
- Reset values: dfi_init_complete_o=0, gpio_init_start_o=0, freq_o=0, busy_o=0, timeout_o=0, state=IDLE, counter=0, done_q=0.
- done_q holds gpio_init_done_i registered each cycle. done_rise = gpio_init_done_i & ~done_q.
- State IDLE:
  - When dfi_init_start_i=1: go to START, capture freq_o<=dfi_frequency_i, counter<=1, drive dfi_init_complete_o<=0.
  - Otherwise dfi_init_complete_o holds its value, so completion persists until the next request.
- State START:
  - gpio_init_start_o remains 0.
  - dfi_init_start_i=0 → IDLE (glitch rejected; complete stays 0).
  - counter==MIN_START_CYCLES → WAIT_DONE, gpio_init_start_o<=1, counter<=0, done_q refreshed.
  - Otherwise counter+1.
  - Result: gpio_init_start_o rises MIN_START_CYCLES+1 cycles after dfi_init_start_i is first sampled high.
- State WAIT_DONE:
  - gpio_init_start_o=1.
  - done_rise → ACK, dfi_init_complete_o<=1.
  - A done level already high on entry is stale and does not count; only a 0→1 transition completes.
  - dfi_init_start_i=0 → IDLE, gpio_init_start_o<=0, complete stays 0.
  - TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1 without done_rise → ERROR, timeout_o<=1, gpio_init_start_o<=0.
  - Otherwise counter+1.
  - Priority order: start deassert > done_rise > timeout.
- State ACK:
  - dfi_init_complete_o=1, gpio_init_start_o=1.
  - dfi_init_start_i=0 → IDLE, gpio_init_start_o<=0, dfi_init_complete_o stays 1.
- State ERROR:
  - dfi_init_complete_o=0, gpio_init_start_o=0.
  - Waits for dfi_init_start_i=0 → IDLE. A new request is not accepted until start has been seen low.
- timeout_o:
  - Set on entry to ERROR.
  - Cleared by timeout_clr_i in any state.
  - Set wins over a simultaneous clear.
- Counter saturates and never wraps.
- freq_o changes only on IDLE→START.
- Reset asserted mid-operation returns all outputs to reset values on the next edge regardless of state.

Test Plan (MIN_START_CYCLES=4, TIMEOUT_CYCLES=16, FREQ_W=5):
- Nominal: start_i=1 and freq=5'd3 at cycle 0 → gpio_init_start_o=1 from cycle 5 and freq_o=3. done_i rises at cycle 10 → complete_o=1 at cycle 11. start_i=0 at 15 → gpio_init_start_o=0 at 16, complete_o stays 1.
- Glitch: start_i high for 2 cycles then low → gpio_init_start_o never rises, complete_o=0, busy_o returns to 0.
- Stale done: done_i=1 held from before the request → no ACK. Firmware drops done to 0 then raises it → complete_o=1 one cycle after the rise.
- Timeout: no done edge for 16 cycles in WAIT_DONE → timeout_o=1, gpio_init_start_o=0, complete_o=0. start_i stays high → no restart. start_i=0 then 1 → new START. timeout_clr_i pulse → timeout_o=0.
- Abort: start_i drops in WAIT_DONE → IDLE next cycle, gpio_init_start_o=0, timeout_o stays 0.
- Reset mid-WAIT_DONE: rst_i=1 for 1 cycle → all outputs 0, state IDLE. A subsequent nominal sequence passes.
